// File: rtl/cim_core_req_router_pkg.sv
// Shared definitions for the CIM core request router: target indices,
// the CIM core address map and the router state encoding.
package cim_core_req_router_pkg;

  localparam int NB_CIM_CORE_COMPONENTS = 4;

  // Target index; the value is also the bit position in the one-hot slave buses.
  typedef enum logic [1:0] {
    SLV_REG_FILE = 2'd0,
    SLV_SRAM     = 2'd1,
    SLV_MACRO    = 2'd2,
    SLV_EDRAM    = 2'd3
  } slvIdx_t;

  // Address map: each target owns the half-open range [base, base + len).
  localparam logic [63:0] REG_FILE_BASE = 64'h0000_0000_2000_0000;
  localparam logic [63:0] REG_FILE_LEN  = 64'h0000_0000_0800_0000;
  localparam logic [63:0] SRAM_BASE     = 64'h0000_0000_2800_0000;
  localparam logic [63:0] SRAM_LEN      = 64'h0000_0000_0800_0000;
  localparam logic [63:0] MACRO_BASE    = 64'h0000_0000_3000_0000;
  localparam logic [63:0] MACRO_LEN     = 64'h0000_0000_2000_0000;
  localparam logic [63:0] EDRAM_BASE    = 64'h0000_0000_5000_0000;
  localparam logic [63:0] EDRAM_LEN     = 64'h0000_0000_2000_0000;

  // Tables indexed by slvIdx_t, so decoders can loop over every target.
  localparam logic [63:0] CIM_CORE_BASE [NB_CIM_CORE_COMPONENTS] =
    '{REG_FILE_BASE, SRAM_BASE, MACRO_BASE, EDRAM_BASE};
  localparam logic [63:0] CIM_CORE_LEN [NB_CIM_CORE_COMPONENTS] =
    '{REG_FILE_LEN, SRAM_LEN, MACRO_LEN, EDRAM_LEN};

  // Router state encoding, kept as plain constants for legacy tools.
  typedef logic [1:0] routerState_t;
  localparam routerState_t ST_IDLE = 2'd0;
  localparam routerState_t ST_FWD  = 2'd1;
  localparam routerState_t ST_WAIT = 2'd2;
  localparam routerState_t ST_RESP = 2'd3;

  // One-hot select vector for a target index.
  function automatic logic [NB_CIM_CORE_COMPONENTS-1:0] idxToOneHot(input slvIdx_t idx);
    return NB_CIM_CORE_COMPONENTS'(1) << idx;
  endfunction

endpackage

// File: rtl/cim_core_addr_decode.sv
// Combinational CIM core address decoder: absolute address to
// {hit, target index, base-relative offset}. Ranges are disjoint, so at
// most one target matches.
module cim_core_addr_decode
  import cim_core_req_router_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output slvIdx_t           idx,
  output logic [ADDR_W-1:0] offset
);

  // Unsigned full-width range compare against every target in the map.
  always_comb begin
    // NOTE: every output gets a default before the loop; a path that leaves
    // one unassigned would infer a latch.
    hit    = 1'b0;
    idx    = SLV_REG_FILE;
    offset = '0;
    for (int i = 0; i < NB_CIM_CORE_COMPONENTS; i++) begin
      if ((addr >= ADDR_W'(CIM_CORE_BASE[i])) &&
          (addr <  ADDR_W'(CIM_CORE_BASE[i] + CIM_CORE_LEN[i]))) begin
        hit    = 1'b1;
        idx    = slvIdx_t'(i[1:0]);
        offset = addr - ADDR_W'(CIM_CORE_BASE[i]);
      end
    end
  end

endmodule

// File: rtl/cim_core_req_router.sv
// Single-outstanding router from one CIM core master to the four CIM core
// targets. A request is decoded on acceptance, forwarded to one target with
// a base-relative offset, and the target's response is returned. Unmapped
// addresses get a local error response without touching any target.
module cim_core_req_router
  import cim_core_req_router_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic                                     req_valid_i,
  output logic                                     req_ready_o,
  input  logic [ADDR_W-1:0]                        req_addr_i,
  input  logic                                     req_we_i,
  input  logic [DATA_W-1:0]                        req_wdata_i,
  input  logic [DATA_W/8-1:0]                      req_be_i,
  output logic                                     rsp_valid_o,
  input  logic                                     rsp_ready_i,
  output logic [DATA_W-1:0]                        rsp_rdata_o,
  output logic                                     rsp_err_o,
  output logic [NB_CIM_CORE_COMPONENTS-1:0]        slv_req_valid_o,
  input  logic [NB_CIM_CORE_COMPONENTS-1:0]        slv_req_ready_i,
  output logic [ADDR_W-1:0]                        slv_addr_o,
  output logic                                     slv_we_o,
  output logic [DATA_W-1:0]                        slv_wdata_o,
  output logic [DATA_W/8-1:0]                      slv_be_o,
  input  logic [NB_CIM_CORE_COMPONENTS-1:0]        slv_rsp_valid_i,
  output logic [NB_CIM_CORE_COMPONENTS-1:0]        slv_rsp_ready_o,
  input  logic [NB_CIM_CORE_COMPONENTS*DATA_W-1:0] slv_rsp_rdata_i,
  input  logic [NB_CIM_CORE_COMPONENTS-1:0]        slv_rsp_err_i
);

  localparam int BE_W = DATA_W / 8;

  routerState_t      state;
  slvIdx_t           idxQ;
  logic [ADDR_W-1:0] offsetQ;
  logic              weQ;
  logic [DATA_W-1:0] wdataQ;
  logic [BE_W-1:0]   beQ;
  logic [DATA_W-1:0] rdataQ;
  logic              errQ;

  logic              decHit;
  slvIdx_t           decIdx;
  logic [ADDR_W-1:0] decOffset;

  cim_core_addr_decode #(
    .ADDR_W (ADDR_W)
  ) u_addr_decode (
    .addr   (req_addr_i),
    .hit    (decHit),
    .idx    (decIdx),
    .offset (decOffset)
  );

  // Transaction FSM plus the request/response holding registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      // NOTE: the datapath registers are reset as well because they drive
      // outputs directly and must read as zero straight after reset.
      state   <= ST_IDLE;
      idxQ    <= SLV_REG_FILE;
      offsetQ <= '0;
      weQ     <= 1'b0;
      wdataQ  <= '0;
      beQ     <= '0;
      rdataQ  <= '0;
      errQ    <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      case (state)
        ST_IDLE: begin
          if (req_valid_i) begin
            idxQ    <= decIdx;
            offsetQ <= decOffset;
            weQ     <= req_we_i;
            wdataQ  <= req_wdata_i;
            beQ     <= req_be_i;
            if (decHit) begin
              state <= ST_FWD;
            end else begin
              rdataQ <= '0;
              errQ   <= 1'b1;
              state  <= ST_RESP;
            end
          end
        end
        ST_FWD: begin
          if (slv_req_ready_i[idxQ]) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (slv_rsp_valid_i[idxQ]) begin
            rdataQ <= slv_rsp_rdata_i[idxQ*DATA_W +: DATA_W];
            errQ   <= slv_rsp_err_i[idxQ];
            state  <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // One-hot slave handshakes, driven from registered state only.
  always_comb begin
    slv_req_valid_o = '0;
    slv_rsp_ready_o = '0;
    if (state == ST_FWD)  slv_req_valid_o = idxToOneHot(idxQ);
    if (state == ST_WAIT) slv_rsp_ready_o = idxToOneHot(idxQ);
  end

  assign req_ready_o = (state == ST_IDLE);
  assign rsp_valid_o = (state == ST_RESP);
  assign rsp_rdata_o = rdataQ;
  assign rsp_err_o   = errQ;
  assign slv_addr_o  = offsetQ;
  assign slv_we_o    = weQ;
  assign slv_wdata_o = wdataQ;
  assign slv_be_o    = beQ;

endmodule

// File: tb/tb_cim_core_req_router.sv
// Self-checking bench for cim_core_req_router. A table-driven address map
// and a phase-by-phase transaction model supply every expected value.
module tb_cim_core_req_router;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 64;
  localparam int NB     = 4;

  // Reference map: [lo, hi) per target index.
  localparam logic [63:0] MAP_LO [NB] = '{64'h2000_0000, 64'h2800_0000, 64'h3000_0000, 64'h5000_0000};
  localparam logic [63:0] MAP_HI [NB] = '{64'h2800_0000, 64'h3000_0000, 64'h5000_0000, 64'h7000_0000};

  logic                   clk_i = 1'b0;
  logic                   rst_ni = 1'b0;
  logic                   req_valid_i = 1'b0;
  logic                   req_ready_o;
  logic [ADDR_W-1:0]      req_addr_i = '0;
  logic                   req_we_i = 1'b0;
  logic [DATA_W-1:0]      req_wdata_i = '0;
  logic [DATA_W/8-1:0]    req_be_i = '0;
  logic                   rsp_valid_o;
  logic                   rsp_ready_i = 1'b0;
  logic [DATA_W-1:0]      rsp_rdata_o;
  logic                   rsp_err_o;
  logic [NB-1:0]          slv_req_valid_o;
  logic [NB-1:0]          slv_req_ready_i = '0;
  logic [ADDR_W-1:0]      slv_addr_o;
  logic                   slv_we_o;
  logic [DATA_W-1:0]      slv_wdata_o;
  logic [DATA_W/8-1:0]    slv_be_o;
  logic [NB-1:0]          slv_rsp_valid_i = '0;
  logic [NB-1:0]          slv_rsp_ready_o;
  logic [NB*DATA_W-1:0]   slv_rsp_rdata_i = '0;
  logic [NB-1:0]          slv_rsp_err_i = '0;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk_i = ~clk_i;

  cim_core_req_router #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_addr_i      (req_addr_i),
    .req_we_i        (req_we_i),
    .req_wdata_i     (req_wdata_i),
    .req_be_i        (req_be_i),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_ready_i     (rsp_ready_i),
    .rsp_rdata_o     (rsp_rdata_o),
    .rsp_err_o       (rsp_err_o),
    .slv_req_valid_o (slv_req_valid_o),
    .slv_req_ready_i (slv_req_ready_i),
    .slv_addr_o      (slv_addr_o),
    .slv_we_o        (slv_we_o),
    .slv_wdata_o     (slv_wdata_o),
    .slv_be_o        (slv_be_o),
    .slv_rsp_valid_i (slv_rsp_valid_i),
    .slv_rsp_ready_o (slv_rsp_ready_o),
    .slv_rsp_rdata_i (slv_rsp_rdata_i),
    .slv_rsp_err_i   (slv_rsp_err_i)
  );

  // Reference decode straight from the address map table.
  function automatic void refDecode(input logic [63:0] a, output bit hit, output int idx,
                                    output logic [63:0] off);
    hit = 1'b0;
    idx = 0;
    off = '0;
    for (int t = 0; t < NB; t++) begin
      if (a >= MAP_LO[t] && a < MAP_HI[t]) begin
        hit = 1'b1;
        idx = t;
        off = a - MAP_LO[t];
      end
    end
  endfunction

  // One full transaction walked phase by phase; the expected outputs of
  // every cycle come from the reference decode and the supplied slave data.
  task automatic runTxn(input string tag, input logic [63:0] addr, input bit we,
                        input logic [63:0] wdata, input logic [7:0] be,
                        input int reqStall, input int rspDelay,
                        input logic [63:0] rdata, input bit err,
                        input int mstStall, input bit spurious);
    bit hit;
    int idx;
    logic [63:0] off;
    logic [3:0] oh;
    logic [63:0] expRdata;
    bit expErr;
    refDecode(addr, hit, idx, off);
    oh = hit ? (4'b0001 << idx) : 4'b0000;
    expRdata = hit ? rdata : 64'h0;
    expErr = hit ? err : 1'b1;

    @(negedge clk_i);
    nChecks++;
    if ({req_ready_o, rsp_valid_o, slv_req_valid_o} !== 6'b10_0000) begin
      nFails++;
      $display("FAIL %s idle: ready/rsp_valid/slv_valid got %b want 100000", tag,
               {req_ready_o, rsp_valid_o, slv_req_valid_o});
    end
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    req_we_i    = we;
    req_wdata_i = wdata;
    req_be_i    = be;

    @(negedge clk_i);
    // Scramble master inputs: the router must use its registered copies.
    req_valid_i = 1'b0;
    req_addr_i  = {$urandom, $urandom};
    req_we_i    = ~we;
    req_wdata_i = {$urandom, $urandom};
    req_be_i    = 8'($urandom);

    if (hit) begin
      for (int k = 0; k <= reqStall; k++) begin
        nChecks++;
        if ({slv_req_valid_o, slv_addr_o, slv_we_o, slv_wdata_o, slv_be_o} !==
            {oh, off, we, wdata, be}) begin
          nFails++;
          $display("FAIL %s fwd[%0d]: valid/addr/we/wdata/be got %b %h %b %h %h want %b %h %b %h %h",
                   tag, k, slv_req_valid_o, slv_addr_o, slv_we_o, slv_wdata_o, slv_be_o,
                   oh, off, we, wdata, be);
        end
        nChecks++;
        if ({rsp_valid_o, req_ready_o, slv_rsp_ready_o} !== 6'b00_0000) begin
          nFails++;
          $display("FAIL %s fwd[%0d]: rsp_valid/req_ready/slv_rsp_ready got %b want 000000",
                   tag, k, {rsp_valid_o, req_ready_o, slv_rsp_ready_o});
        end
        slv_req_ready_i = (k == reqStall) ? oh : (4'($urandom) & ~oh);
        @(negedge clk_i);
      end
      slv_req_ready_i = '0;

      for (int k = 0; k <= rspDelay; k++) begin
        nChecks++;
        if ({slv_rsp_ready_o, slv_req_valid_o, rsp_valid_o} !== {oh, 4'b0000, 1'b0}) begin
          nFails++;
          $display("FAIL %s wait[%0d]: slv_rsp_ready/slv_req_valid/rsp_valid got %b want %b",
                   tag, k, {slv_rsp_ready_o, slv_req_valid_o, rsp_valid_o}, {oh, 5'b0});
        end
        slv_rsp_rdata_i = {$urandom, $urandom, $urandom, $urandom,
                           $urandom, $urandom, $urandom, $urandom};
        slv_rsp_rdata_i[idx*DATA_W +: DATA_W] = rdata;
        slv_rsp_err_i = 4'($urandom);
        slv_rsp_err_i[idx] = err;
        slv_rsp_valid_i = (k == rspDelay) ? oh : 4'b0000;
        if (spurious) slv_rsp_valid_i = slv_rsp_valid_i | (4'b1111 & ~oh);
        @(negedge clk_i);
      end
      slv_rsp_valid_i = '0;
      slv_rsp_rdata_i = {$urandom, $urandom, $urandom, $urandom,
                         $urandom, $urandom, $urandom, $urandom};
      slv_rsp_err_i   = 4'($urandom);
    end

    for (int k = 0; k <= mstStall; k++) begin
      nChecks++;
      if ({rsp_valid_o, rsp_rdata_o, rsp_err_o} !== {1'b1, expRdata, expErr}) begin
        nFails++;
        $display("FAIL %s resp[%0d]: valid/rdata/err got %b %h %b want 1 %h %b",
                 tag, k, rsp_valid_o, rsp_rdata_o, rsp_err_o, expRdata, expErr);
      end
      nChecks++;
      if ({req_ready_o, slv_req_valid_o, slv_rsp_ready_o} !== 9'b0) begin
        nFails++;
        $display("FAIL %s resp[%0d]: req_ready/slv_req_valid/slv_rsp_ready got %b want 0",
                 tag, k, {req_ready_o, slv_req_valid_o, slv_rsp_ready_o});
      end
      rsp_ready_i = (k == mstStall);
      // A request offered while the response is pending must be ignored.
      req_valid_i = 1'b1;
      req_addr_i  = 64'h2000_0000;
      @(negedge clk_i);
    end
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b0;
    nChecks++;
    if ({rsp_valid_o, req_ready_o, slv_req_valid_o} !== 6'b01_0000) begin
      nFails++;
      $display("FAIL %s done: rsp_valid/req_ready/slv_req_valid got %b want 010000",
               tag, {rsp_valid_o, req_ready_o, slv_req_valid_o});
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    nChecks++;
    if ({req_ready_o, rsp_valid_o, slv_req_valid_o, slv_rsp_ready_o, rsp_err_o} !== 11'b100_0000_0000) begin
      nFails++;
      $display("FAIL reset controls got %b want 10000000000",
               {req_ready_o, rsp_valid_o, slv_req_valid_o, slv_rsp_ready_o, rsp_err_o});
    end
    nChecks++;
    if ({rsp_rdata_o, slv_addr_o, slv_wdata_o, slv_be_o, slv_we_o} !== '0) begin
      nFails++;
      $display("FAIL reset data got %h %h %h %h %b want all zero",
               rsp_rdata_o, slv_addr_o, slv_wdata_o, slv_be_o, slv_we_o);
    end
    rst_ni = 1'b1;
  endtask

  task automatic test_sram_read();
    runTxn("sram_read", 64'h2800_0010, 1'b0, 64'h0, 8'hFF, 0, 0,
           64'hA5A5_0000_0000_0001, 1'b0, 0, 1'b0);
  endtask

  task automatic test_edram_stall_write();
    runTxn("edram_stall_write", 64'h6FFF_FFF8, 1'b1, 64'hDEAD_BEEF_0123_4567, 8'hFF, 5, 0,
           64'h0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_decode_miss();
    runTxn("miss_7000", 64'h7000_0000, 1'b0, 64'h0, 8'hFF, 0, 0, 64'h0, 1'b0, 0, 1'b0);
    runTxn("miss_1fff", 64'h1FFF_FFFF, 1'b0, 64'h0, 8'hFF, 0, 0, 64'h0, 1'b0, 0, 1'b0);
    runTxn("miss_max", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h1234, 8'h0F, 0, 0, 64'h0, 1'b0, 1, 1'b0);
  endtask

  task automatic test_boundaries();
    runTxn("regfile_top_be0", 64'h27FF_FFFF, 1'b1, 64'h5555_AAAA_5555_AAAA, 8'h00, 1, 1,
           64'h0, 1'b0, 0, 1'b0);
    runTxn("macro_top", 64'h4FFF_FFFF, 1'b0, 64'h0, 8'hF0, 0, 2, 64'h0BAD_F00D_CAFE_0001, 1'b0, 0, 1'b0);
    runTxn("edram_base", 64'h5000_0000, 1'b0, 64'h0, 8'h01, 2, 0, 64'h1111_2222_3333_4444, 1'b0, 0, 1'b0);
  endtask

  task automatic test_macro_err_backpressure();
    runTxn("macro_err", 64'h3000_0000, 1'b0, 64'h0, 8'hFF, 0, 1, 64'hFEED_0000_0000_BEEF, 1'b1, 3, 1'b0);
  endtask

  task automatic test_spurious_rsp();
    runTxn("spurious", 64'h2800_0100, 1'b0, 64'h0, 8'hFF, 0, 2, 64'h0123_4567_89AB_CDEF, 1'b0, 0, 1'b1);
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk_i);
    req_valid_i = 1'b1;
    req_addr_i  = 64'h2800_0040;
    req_we_i    = 1'b1;
    req_wdata_i = 64'hCAFE_CAFE_CAFE_CAFE;
    req_be_i    = 8'h3C;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    slv_req_ready_i = 4'b0010;
    @(negedge clk_i);
    slv_req_ready_i = 4'b0000;
    nChecks++;
    if (slv_rsp_ready_o !== 4'b0010) begin
      nFails++;
      $display("FAIL rst_wait pre: slv_rsp_ready got %b want 0010", slv_rsp_ready_o);
    end
    rst_ni = 1'b0;
    @(negedge clk_i);
    nChecks++;
    if ({req_ready_o, rsp_valid_o, slv_req_valid_o, slv_rsp_ready_o} !== 10'b10_0000_0000) begin
      nFails++;
      $display("FAIL rst_wait controls got %b want 1000000000",
               {req_ready_o, rsp_valid_o, slv_req_valid_o, slv_rsp_ready_o});
    end
    nChecks++;
    if ({rsp_rdata_o, rsp_err_o, slv_addr_o, slv_wdata_o, slv_be_o, slv_we_o} !== '0) begin
      nFails++;
      $display("FAIL rst_wait data got %h %b %h %h %h %b want all zero",
               rsp_rdata_o, rsp_err_o, slv_addr_o, slv_wdata_o, slv_be_o, slv_we_o);
    end
    rst_ni = 1'b1;
    runTxn("post_reset", 64'h2000_0000, 1'b0, 64'h0, 8'hFF, 0, 0, 64'h7777_0000_8888_0000, 1'b0, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [63:0] a;
    int t;
    int kind;
    for (int n = 0; n < 40; n++) begin
      t = $urandom_range(0, NB - 1);
      kind = $urandom_range(0, 5);
      case (kind)
        0: a = MAP_LO[t] + ({$urandom, $urandom} % (MAP_HI[t] - MAP_LO[t]));
        1: a = MAP_LO[t];
        2: a = MAP_HI[t] - 64'd1;
        3: a = {$urandom, $urandom};
        4: a = MAP_HI[t];
        default: a = 64'h2000_0000 - 64'd1 - 64'($urandom);
      endcase
      runTxn("random", a, 1'($urandom), {$urandom, $urandom}, 8'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 3), {$urandom, $urandom},
             1'($urandom), $urandom_range(0, 2), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_sram_read();
    test_edram_stall_write();
    test_decode_miss();
    test_boundaries();
    test_macro_err_backpressure();
    test_spurious_rsp();
    test_reset_in_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  // Global time bound in case the run stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
